// File: rtl/hpdmc_sdr_datactl.sv
// hpdmc_sdr_datactl: DQ-bus sequencer for a 16-bit SDR SDRAM.
// Drives the tristate buffer for write bursts, captures read bursts
// CAS_LATENCY cycles after the command, and tells the command manager
// when a READ or WRITE can be issued without a bus collision.
// wr_data_ack and proto_err answer the command in the cycle it is issued,
// so they are decoded from registered state plus the command inputs; every
// other output comes straight from a flop.
module hpdmc_sdr_datactl #(
  parameter int BURST_LEN   = 4,
  parameter int CAS_LATENCY = 2,
  parameter int TURNAROUND  = 1
) (
  input  logic        sys_clk,
  input  logic        sdram_rst,
  input  logic        read,
  input  logic        write,
  output logic        read_safe,
  output logic        write_safe,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_mask,
  output logic        wr_data_ack,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic [15:0] dq_t,
  output logic [15:0] dq_o,
  input  logic [15:0] dq_i,
  output logic [1:0]  sdram_dqm,
  output logic        proto_err
);

  // Window counters must hold the longest blocking window (read -> write).
  localparam int CW = $clog2(CAS_LATENCY + BURST_LEN + TURNAROUND + 1);
  localparam int BW = $clog2(BURST_LEN + 1);

  localparam logic [CW-1:0] RD_AFTER_RD = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] RD_AFTER_WR = CW'(BURST_LEN);
  localparam logic [CW-1:0] WR_AFTER_WR = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] WR_AFTER_RD = CW'(CAS_LATENCY + BURST_LEN + TURNAROUND - 1);
  localparam logic [BW-1:0] BEATS_M1    = BW'(BURST_LEN - 1);

  logic [CW-1:0]          rs_cnt_q, rs_cnt_d, rs_dec;
  logic [CW-1:0]          ws_cnt_q, ws_cnt_d, ws_dec;
  logic                   read_safe_q, write_safe_q;
  logic [BW-1:0]          wcnt_q, wcnt_d;
  logic [BW-1:0]          rcnt_q, rcnt_d;
  logic [CAS_LATENCY:0]   tok_q, tok_d;
  logic                   acc_rd, acc_wr, ack, capture, perr;
  logic [15:0]            dq_t_q, dq_o_q, rd_data_q;
  logic [1:0]             dqm_q;
  logic                   rd_valid_q;

  function automatic logic [CW-1:0] umax(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Command acceptance, protocol-error decode and write-beat handshake.
  // On a simultaneous read+write the read wins and the write is dropped.
  always_comb begin
    acc_rd = read & read_safe_q & ~sdram_rst;
    acc_wr = write & ~read & write_safe_q & ~sdram_rst;
    ack    = acc_wr | (wcnt_q != '0);
    perr   = ~sdram_rst & ((read & write) | (read & ~read_safe_q) | (write & ~write_safe_q));
  end

  // Next-state for the safe-window counters, beat counters and read tokens.
  // Overlapping windows are merged by keeping the larger remaining count.
  always_comb begin
    rs_dec   = (rs_cnt_q != '0) ? rs_cnt_q - CW'(1) : '0;
    ws_dec   = (ws_cnt_q != '0) ? ws_cnt_q - CW'(1) : '0;
    rs_cnt_d = rs_dec;
    ws_cnt_d = ws_dec;
    if (acc_rd) begin
      rs_cnt_d = umax(rs_dec, RD_AFTER_RD);
      ws_cnt_d = umax(ws_dec, WR_AFTER_RD);
    end else if (acc_wr) begin
      rs_cnt_d = umax(rs_dec, RD_AFTER_WR);
      ws_cnt_d = umax(ws_dec, WR_AFTER_WR);
    end

    wcnt_d = (wcnt_q != '0) ? wcnt_q - BW'(1) : '0;
    if (acc_wr) wcnt_d = BEATS_M1;

    // Token reaches the top of the chain in the cycle the first beat is on DQ.
    tok_d   = {tok_q[CAS_LATENCY-1:0], acc_rd};
    capture = tok_q[CAS_LATENCY] | (rcnt_q != '0);
    rcnt_d  = (rcnt_q != '0) ? rcnt_q - BW'(1) : '0;
    if (tok_q[CAS_LATENCY]) rcnt_d = BEATS_M1;
  end

  // Control state registers; reset drops every pending window and beat.
  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      rs_cnt_q     <= '0;
      ws_cnt_q     <= '0;
      read_safe_q  <= 1'b1;
      write_safe_q <= 1'b1;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      tok_q        <= '0;
    end else begin
      rs_cnt_q     <= rs_cnt_d;
      ws_cnt_q     <= ws_cnt_d;
      read_safe_q  <= (rs_cnt_d == '0);
      write_safe_q <= (ws_cnt_d == '0);
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      tok_q        <= tok_d;
    end
  end

  // Data-path registers: write beat onto the pins one cycle after ack,
  // read beat captured from DQ and presented the following cycle.
  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      dq_t_q     <= 16'hFFFF;
      dq_o_q     <= '0;
      dqm_q      <= 2'b00;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      dq_t_q     <= {16{~ack}};
      dq_o_q     <= ack ? wr_data : dq_o_q;
      dqm_q      <= ack ? ~wr_mask : 2'b00;
      rd_valid_q <= capture;
      rd_data_q  <= capture ? dq_i : rd_data_q;
    end
  end

  assign read_safe   = read_safe_q;
  assign write_safe  = write_safe_q;
  assign wr_data_ack = ack;
  assign proto_err   = perr;
  assign dq_t        = dq_t_q;
  assign dq_o        = dq_o_q;
  assign sdram_dqm   = dqm_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_hpdmc_sdr_datactl.sv
// Bench for hpdmc_sdr_datactl. The reference model marks, per absolute
// cycle, the intervals each accepted command occupies (ack beats, driven
// beats, read beats, unsafe windows) and compares the whole output vector.
module tb_hpdmc_sdr_datactl;
  localparam int BL   = 4;
  localparam int CL   = 2;
  localparam int TA   = 1;
  localparam int MAXC = 512;

  logic        sys_clk = 1'b0;
  logic        sdram_rst, read, write;
  logic        read_safe, write_safe, wr_data_ack, rd_valid, proto_err;
  logic [15:0] wr_data, rd_data, dq_t, dq_o, dq_i;
  logic [1:0]  wr_mask, sdram_dqm;

  typedef struct packed {
    logic [15:0] dqt;
    logic [15:0] dqo;
    logic [1:0]  dqm;
    logic        ack;
    logic        rv;
    logic [15:0] rdd;
    logic        rs;
    logic        ws;
    logic        perr;
  } ov_t;

  ov_t         obs [MAXC];
  bit          m_rs_low [MAXC], m_ws_low [MAXC], m_ack [MAXC], m_drv [MAXC], m_rv [MAXC], m_perr [MAXC];
  logic [15:0] m_dqo [MAXC], m_rd [MAXC], wd_tab [MAXC], dqi_plan [MAXC];
  logic [1:0]  m_dqm [MAXC], wm_tab [MAXC];
  int          n_cmp = 0;
  int          n_err = 0;

  hpdmc_sdr_datactl #(.BURST_LEN(BL), .CAS_LATENCY(CL), .TURNAROUND(TA)) dut (
    .sys_clk(sys_clk), .sdram_rst(sdram_rst), .read(read), .write(write),
    .read_safe(read_safe), .write_safe(write_safe),
    .wr_data(wr_data), .wr_mask(wr_mask), .wr_data_ack(wr_data_ack),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .dq_t(dq_t), .dq_o(dq_o), .dq_i(dq_i),
    .sdram_dqm(sdram_dqm), .proto_err(proto_err)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic ov_t expv(input int c);
    ov_t e;
    e.dqt  = m_drv[c] ? 16'h0000 : 16'hFFFF;
    e.dqo  = m_drv[c] ? m_dqo[c] : 16'h0000;
    e.dqm  = m_drv[c] ? m_dqm[c] : 2'b00;
    e.ack  = m_ack[c];
    e.rv   = m_rv[c];
    e.rdd  = m_rv[c] ? m_rd[c] : 16'h0000;
    e.rs   = !m_rs_low[c];
    e.ws   = !m_ws_low[c];
    e.perr = m_perr[c];
    return e;
  endfunction

  // Fresh model, fresh random data/bus tables, DUT held in reset two edges.
  task automatic start_scn();
    for (int c = 0; c < MAXC; c++) begin
      m_rs_low[c] = 0; m_ws_low[c] = 0; m_ack[c] = 0; m_drv[c] = 0; m_rv[c] = 0; m_perr[c] = 0;
      m_dqo[c] = '0; m_rd[c] = '0; m_dqm[c] = '0;
      wd_tab[c] = 16'($urandom); wm_tab[c] = 2'($urandom); dqi_plan[c] = 16'($urandom);
      obs[c] = '0;
    end
    sdram_rst = 1'b1; read = 1'b0; write = 1'b0; wr_data = '0; wr_mask = '0; dq_i = '0;
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  // One bus cycle: drive inputs, advance the model, record outputs mid-cycle.
  task automatic step(input int c, input bit rd, input bit wr, input bit rst);
    read = rd; write = wr; sdram_rst = rst;
    wr_data = wd_tab[c]; wr_mask = wm_tab[c]; dq_i = dqi_plan[c];
    if (rst) begin
      m_perr[c] = 0;
      for (int j = c + 1; j < MAXC; j++) begin
        m_rs_low[j] = 0; m_ws_low[j] = 0; m_ack[j] = 0; m_drv[j] = 0; m_rv[j] = 0;
      end
    end else begin
      m_perr[c] = (rd && wr) || (rd && m_rs_low[c]) || (wr && m_ws_low[c]);
      if (rd && !m_rs_low[c]) begin
        for (int k = 0; k < BL; k++) begin
          m_rv[c+2+CL+k] = 1;
          m_rd[c+2+CL+k] = dqi_plan[c+1+CL+k];
        end
        for (int j = c + 1; j <= c + BL - 1; j++) m_rs_low[j] = 1;
        for (int j = c + 1; j <= c + CL + BL + TA - 1; j++) m_ws_low[j] = 1;
      end else if (wr && !rd && !m_ws_low[c]) begin
        for (int k = 0; k < BL; k++) begin
          m_ack[c+k]   = 1;
          m_drv[c+1+k] = 1;
          m_dqo[c+1+k] = wd_tab[c+k];
          m_dqm[c+1+k] = ~wm_tab[c+k];
        end
        for (int j = c + 1; j <= c + BL; j++) m_rs_low[j] = 1;
        for (int j = c + 1; j <= c + BL - 1; j++) m_ws_low[j] = 1;
      end
    end
    @(negedge sys_clk);
    obs[c].dqt  = dq_t;
    obs[c].dqo  = (dq_t[0] === 1'b0) ? dq_o : 16'h0000;
    obs[c].dqm  = sdram_dqm;
    obs[c].ack  = wr_data_ack;
    obs[c].rv   = rd_valid;
    obs[c].rdd  = (rd_valid === 1'b1) ? rd_data : 16'h0000;
    obs[c].rs   = read_safe;
    obs[c].ws   = write_safe;
    obs[c].perr = proto_err;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    start_scn();
    for (int c = 0; c < 20; c++) step(c, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (obs[c] !== expv(c)) begin
        n_err++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
      end
    end
    n_cmp++;
    if (obs[0].dqt !== 16'hFFFF || obs[0].rs !== 1'b1 || obs[0].ws !== 1'b1 || obs[0].rv !== 1'b0 || obs[0].dqm !== 2'b00) begin
      n_err++; $display("FAIL reset_values got=%h exp dqt=ffff rs=1 ws=1 rv=0 dqm=0", obs[0]);
    end
  endtask

  task automatic test_write();
    int fails;
    start_scn();
    wd_tab[10] = 16'h1111; wd_tab[11] = 16'h2222; wd_tab[12] = 16'h3333; wd_tab[13] = 16'h4444;
    wm_tab[10] = 2'b11; wm_tab[11] = 2'b11; wm_tab[12] = 2'b01; wm_tab[13] = 2'b11;
    for (int c = 0; c < 30; c++) step(c, 0, c == 10, 0);
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if (obs[c] !== expv(c)) begin
        n_err++; $display("FAIL write cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
      end
    end
    fails = 0;
    if (obs[9].ack !== 1'b0 || obs[10].ack !== 1'b1 || obs[13].ack !== 1'b1 || obs[14].ack !== 1'b0) fails++;
    if (obs[11].dqo !== 16'h1111 || obs[14].dqo !== 16'h4444 || obs[13].dqm !== 2'b10 || obs[12].dqm !== 2'b00) fails++;
    if (obs[10].dqt !== 16'hFFFF || obs[11].dqt !== 16'h0000 || obs[14].dqt !== 16'h0000 || obs[15].dqt !== 16'hFFFF) fails++;
    if (obs[10].rs !== 1'b1 || obs[11].rs !== 1'b0 || obs[14].rs !== 1'b0 || obs[15].rs !== 1'b1) fails++;
    n_cmp++;
    if (fails != 0) begin
      n_err++; $display("FAIL write_fixed got %0d bad groups exp 0", fails);
    end
  endtask

  task automatic test_read();
    int fails;
    start_scn();
    dqi_plan[13] = 16'h00A0; dqi_plan[14] = 16'h00A1; dqi_plan[15] = 16'h00A2; dqi_plan[16] = 16'h00A3;
    for (int c = 0; c < 30; c++) step(c, c == 10, 0, 0);
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if (obs[c] !== expv(c)) begin
        n_err++; $display("FAIL read cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
      end
    end
    fails = 0;
    if (obs[13].rv !== 1'b0 || obs[14].rdd !== 16'h00A0 || obs[17].rdd !== 16'h00A3 || obs[18].rv !== 1'b0) fails++;
    if (obs[11].ws !== 1'b0 || obs[16].ws !== 1'b0 || obs[17].ws !== 1'b1) fails++;
    for (int c = 0; c < 30; c++) if (obs[c].dqt !== 16'hFFFF) fails++;
    n_cmp++;
    if (fails != 0) begin
      n_err++; $display("FAIL read_fixed got %0d bad checks exp 0", fails);
    end
  endtask

  task automatic test_back_to_back();
    int nv;
    start_scn();
    for (int c = 0; c < 30; c++) step(c, c == 10 || c == 14, 0, 0);
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if (obs[c] !== expv(c)) begin
        n_err++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
      end
    end
    nv = 0;
    for (int c = 14; c <= 21; c++) if (obs[c].rv === 1'b1) nv++;
    n_cmp++;
    if (nv != 8 || obs[22].rv !== 1'b0 || obs[14].perr !== 1'b0) begin
      n_err++; $display("FAIL b2b_contig got %0d valid beats in 14..21 exp 8", nv);
    end
  endtask

  task automatic test_unsafe_read();
    int nv;
    start_scn();
    for (int c = 0; c < 30; c++) step(c, c == 10 || c == 12, 0, 0);
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if (obs[c] !== expv(c)) begin
        n_err++; $display("FAIL unsafe_read cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
      end
    end
    nv = 0;
    for (int c = 0; c < 30; c++) if (obs[c].rv === 1'b1) nv++;
    n_cmp++;
    if (obs[12].perr !== 1'b1 || obs[11].perr !== 1'b0 || obs[13].perr !== 1'b0 || nv != 4) begin
      n_err++; $display("FAIL unsafe_read_pulse got perr12=%b beats=%0d exp perr12=1 beats=4", obs[12].perr, nv);
    end
  endtask

  task automatic test_both_cmds();
    start_scn();
    for (int c = 0; c < 30; c++) step(c, c == 10, c == 10 || c == 12, 0);
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if (obs[c] !== expv(c)) begin
        n_err++; $display("FAIL both_cmds cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
      end
    end
    n_cmp++;
    if (obs[10].perr !== 1'b1 || obs[10].ack !== 1'b0 || obs[12].perr !== 1'b1 || obs[14].rv !== 1'b1) begin
      n_err++; $display("FAIL both_cmds_fixed got perr10=%b ack10=%b perr12=%b rv14=%b exp 1 0 1 1",
                        obs[10].perr, obs[10].ack, obs[12].perr, obs[14].rv);
    end
  endtask

  task automatic test_turnaround();
    int fails;
    start_scn();
    for (int c = 0; c < 30; c++) step(c, c == 10, c == 17, 0);
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if (obs[c] !== expv(c)) begin
        n_err++; $display("FAIL turnaround cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
      end
    end
    fails = 0;
    for (int c = 13; c <= 17; c++) if (obs[c].dqt !== 16'hFFFF) fails++;
    for (int c = 18; c <= 21; c++) if (obs[c].dqt !== 16'h0000) fails++;
    if (obs[17].ack !== 1'b1 || obs[17].perr !== 1'b0 || obs[22].dqt !== 16'hFFFF) fails++;
    n_cmp++;
    if (fails != 0) begin
      n_err++; $display("FAIL turnaround_bus got %0d bad checks exp 0", fails);
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    start_scn();
    for (int c = 0; c < 30; c++) step(c, c == 10, 0, c == 15);
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if (obs[c] !== expv(c)) begin
        n_err++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", c, obs[c], expv(c));
      end
    end
    nv = 0;
    for (int c = 16; c < 30; c++) if (obs[c].rv === 1'b1) nv++;
    n_cmp++;
    if (nv != 0 || obs[15].rv !== 1'b1 || obs[16].rs !== 1'b1 || obs[16].ws !== 1'b1 || obs[16].dqt !== 16'hFFFF) begin
      n_err++; $display("FAIL reset_mid_drop got late beats=%0d rs16=%b ws16=%b exp 0 1 1", nv, obs[16].rs, obs[16].ws);
    end
  endtask

  task automatic test_random();
    bit rd, wr, rst;
    for (int r = 0; r < 3; r++) begin
      start_scn();
      for (int c = 0; c < 400; c++) begin
        rd  = ($urandom_range(0, 3) == 0);
        wr  = ($urandom_range(0, 2) == 0);
        rst = (c > 5) && ($urandom_range(0, 120) == 0);
        step(c, rd, wr, rst);
      end
      for (int c = 0; c < 400; c++) begin
        n_cmp++;
        if (obs[c] !== expv(c)) begin
          n_err++; $display("FAIL random r=%0d cyc=%0d got=%h exp=%h", r, c, obs[c], expv(c));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_unsafe_read();
    test_both_cmds();
    test_turnaround();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
